// File: rtl/whack_pkg.sv
// Shared state encodings and level arithmetic for the whack-a-mole game sequencer.
package whack_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PLAY      = 2'd1;
  localparam logic [1:0] OVER      = 2'd2;
  localparam logic [1:0] MAX_LEVEL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_PLAY = PLAY,
    ST_OVER = OVER
  } state_e;

  // Score needed to leave level lvl; kept 9 bits wide so (lvl+1)*step cannot wrap.
  function automatic logic [8:0] level_threshold(input logic [1:0] lvl, input logic [8:0] step);
    return (9'(lvl) + 9'd1) * step;
  endfunction

endpackage

// File: rtl/second_ticker.sv
// Game-second prescaler: one-cycle tick every CLK_HZ enabled cycles, parked at 0 when disabled.
module second_ticker #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  assign tick = enable && (count_q == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/level_controller.sv
// Game-session sequencer for the whack-a-mole datapath: start/seed capture, round timer,
// score-driven level ramp and end-of-round score latch.
module level_controller
  import whack_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          GAME_SECONDS = 60,
  parameter int          LEVEL_STEP   = 10,
  parameter logic [27:0] BASE_SPEED   = 28'd149_999_999
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  score,
  output logic        game,
  output logic [1:0]  seed,
  output logic [27:0] speed,
  output logic [1:0]  level,
  output logic [6:0]  time_left,
  output logic        game_over,
  output logic [7:0]  final_score
);

  localparam logic [6:0] ROUND_SECS = 7'(GAME_SECONDS);
  localparam logic [8:0] STEP       = 9'(LEVEL_STEP);

  state_e      state_q;
  logic        start_q;
  logic [1:0]  seed_cnt_q;
  logic [1:0]  seed_q;
  logic        game_q;
  logic        game_over_q;
  logic [1:0]  level_q;
  logic [27:0] speed_q;
  logic [6:0]  time_left_q;
  logic [7:0]  final_score_q;

  logic start_edge;
  logic tick;
  logic level_up;

  assign start_edge = start & ~start_q;
  assign level_up   = (level_q < MAX_LEVEL) && ({1'b0, score} >= level_threshold(level_q, STEP));

  second_ticker #(
    .CLK_HZ(CLK_HZ)
  ) u_ticker (
    .clock  (clock),
    .reset_n(reset_n),
    .enable (state_q == ST_PLAY),
    .tick   (tick)
  );

  // start_q resets high so a button held through reset release is not seen as an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b1;
      seed_cnt_q    <= 2'b00;
      seed_q        <= 2'b01;
      game_q        <= 1'b0;
      game_over_q   <= 1'b0;
      level_q       <= 2'd0;
      speed_q       <= BASE_SPEED;
      time_left_q   <= 7'd0;
      final_score_q <= 8'd0;
    end else begin
      start_q    <= start;
      seed_cnt_q <= seed_cnt_q + 2'd1;
      speed_q    <= BASE_SPEED >> level_q;
      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state_q     <= ST_PLAY;
            game_q      <= 1'b1;
            game_over_q <= 1'b0;
            seed_q      <= (seed_cnt_q == 2'b00) ? 2'b01 : seed_cnt_q;
            time_left_q <= ROUND_SECS;
            level_q     <= 2'd0;
          end
        end
        ST_PLAY: begin
          // Round end takes priority and freezes the level on the final tick.
          if (tick && time_left_q == 7'd1) begin
            state_q       <= ST_OVER;
            game_q        <= 1'b0;
            game_over_q   <= 1'b1;
            time_left_q   <= 7'd0;
            final_score_q <= score;
          end else begin
            if (tick) begin
              time_left_q <= time_left_q - 7'd1;
            end
            if (level_up) begin
              level_q <= level_q + 2'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          game_q      <= 1'b0;
          game_over_q <= 1'b0;
        end
      endcase
    end
  end

  assign game        = game_q;
  assign game_over   = game_over_q;
  assign seed        = seed_q;
  assign speed       = speed_q;
  assign level       = level_q;
  assign time_left   = time_left_q;
  assign final_score = final_score_q;

endmodule

// File: tb/tb_level_controller.sv
// Scenario bench for level_controller, checked against a cycle-level model of the game
// session computed from elapsed round time and score thresholds.
`timescale 1ns/1ps
module tb_level_controller;

  localparam int          HZ    = 4;
  localparam int          GS    = 3;
  localparam int          STEP  = 2;
  localparam logic [27:0] BASE  = 28'd64;
  localparam int          ROUND = GS * HZ;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [7:0]  score   = 8'd0;
  logic        game;
  logic        game_over;
  logic [1:0]  seed;
  logic [1:0]  level;
  logic [27:0] speed;
  logic [6:0]  time_left;
  logic [7:0]  final_score;
  logic [48:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: phase 0 idle, 1 playing, 2 over.
  int m_cyc;
  int m_phase;
  int m_elapsed;
  int m_seed;
  int m_level;
  int m_tl;
  int m_final;
  int m_speed;
  bit m_prev_start;

  level_controller #(
    .CLK_HZ      (HZ),
    .GAME_SECONDS(GS),
    .LEVEL_STEP  (STEP),
    .BASE_SPEED  (BASE)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .score      (score),
    .game       (game),
    .seed       (seed),
    .speed      (speed),
    .level      (level),
    .time_left  (time_left),
    .game_over  (game_over),
    .final_score(final_score)
  );

  always #5 clock = ~clock;

  assign dut_vec = {game, game_over, seed, level, speed, time_left, final_score};

  function automatic logic [48:0] exp_vec();
    return {m_phase == 1, m_phase == 2, 2'(m_seed), 2'(m_level), 28'(m_speed), 7'(m_tl), 8'(m_final)};
  endfunction

  task automatic model_reset();
    m_cyc        = 0;
    m_prev_start = 1'b1;
    m_phase      = 0;
    m_elapsed    = 0;
    m_seed       = 1;
    m_level      = 0;
    m_tl         = 0;
    m_final      = 0;
    m_speed      = int'(BASE);
  endtask

  task automatic model_edge();
    bit edge_seen;
    int cnt;
    int speed_next;
    edge_seen    = start && !m_prev_start;
    m_prev_start = start;
    cnt          = m_cyc % 4;
    m_cyc++;
    speed_next   = int'(BASE) >> m_level;
    if (m_phase == 1) begin
      m_elapsed++;
      if (m_elapsed == ROUND) begin
        m_phase = 2;
        m_tl    = 0;
        m_final = int'(score);
      end else begin
        m_tl = GS - m_elapsed / HZ;
        if (m_level < 3 && int'(score) >= (m_level + 1) * STEP) m_level++;
      end
    end else if (edge_seen) begin
      m_phase   = 1;
      m_elapsed = 0;
      m_tl      = GS;
      m_level   = 0;
      m_seed    = (cnt == 0) ? 1 : cnt;
    end
    m_speed = speed_next;
  endtask

  task automatic cyc();
    @(posedge clock);
    if (reset_n) model_edge();
    @(negedge clock);
  endtask

  task automatic test_reset();
    start   = 1'b1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) cyc();
    n_cmp++;
    if (dut_vec !== {2'b00, 2'b01, 2'b00, BASE, 7'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_values: got %h want %h", dut_vec, {2'b00, 2'b01, 2'b00, BASE, 7'd0, 8'd0});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (game !== 1'b0 || game_over !== 1'b0 || seed !== 2'b01) begin
        n_bad++;
        $display("FAIL held_start cyc %0d: game=%b over=%b seed=%b want 0 0 01", i, game, game_over, seed);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL held_start_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    start = 1'b0;
    cyc();
    $display("test_reset: start held through release, game=%b seed=%b", game, seed);
  endtask

  task automatic test_round_timing();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++;
    if (game !== 1'b1 || time_left !== 7'(GS)) begin
      n_bad++;
      $display("FAIL start_latency: game=%b time_left=%0d want 1 %0d", game, time_left, GS);
    end
    for (int i = 1; i <= ROUND + 2; i++) begin
      score = 8'($urandom_range(0, 9));
      cyc();
      n_cmp++;
      if (game !== (i < ROUND) || game_over !== (i >= ROUND) ||
          time_left !== 7'((i < ROUND) ? GS - i / HZ : 0)) begin
        n_bad++;
        $display("FAIL round_timing cyc %0d: game=%b over=%b time_left=%0d", i, game, game_over, time_left);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL round_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    $display("test_round_timing: round over, final_score=%0d", final_score);
  endtask

  task automatic test_level_steps();
    int steps[5] = '{0, 2, 4, 6, 8};
    int lv[5]    = '{0, 1, 2, 3, 3};
    score = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      score = 8'(steps[k]);
      repeat (2) begin
        cyc();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_bad++;
          $display("FAIL level_model score %0d: got %h want %h", steps[k], dut_vec, exp_vec());
        end
      end
      n_cmp++;
      if (level !== 2'(lv[k]) || speed !== (BASE >> lv[k])) begin
        n_bad++;
        $display("FAIL level_step score %0d: level=%0d speed=%0d want %0d %0d",
                 steps[k], level, speed, lv[k], BASE >> lv[k]);
      end
    end
    score = 8'd1;
    cyc();
    n_cmp++;
    if (level !== 2'd3) begin
      n_bad++;
      $display("FAIL level_hold: level=%0d want 3", level);
    end
    repeat (3) begin
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL level_tail: got %h want %h", dut_vec, exp_vec());
      end
    end
    $display("test_level_steps: level=%0d speed=%0d over=%b", level, speed, game_over);
  endtask

  task automatic test_jump();
    score = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    score = 8'd8;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_cmp++;
      if (level !== 2'((k < 3) ? k : 3) || (k == 4 && speed !== 28'd8)) begin
        n_bad++;
        $display("FAIL level_jump cyc %0d: level=%0d speed=%0d", k, level, speed);
      end
    end
    repeat (ROUND) begin
      score = 8'($urandom_range(0, 12));
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL jump_model: got %h want %h", dut_vec, exp_vec());
      end
    end
    $display("test_jump: jump to level 3 one step per cycle, over=%b", game_over);
  endtask

  task automatic test_seed();
    for (int want = 0; want <= 2; want += 2) begin
      int guard = 0;
      while (m_cyc % 4 != want && guard < 8) begin
        cyc();
        guard++;
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_cmp++;
      if (seed !== ((want == 0) ? 2'b01 : 2'b10)) begin
        n_bad++;
        $display("FAIL seed_capture counter %0d: seed=%b", want, seed);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL seed_model counter %0d: got %h want %h", want, dut_vec, exp_vec());
      end
      repeat (ROUND + 1) begin
        score = 8'($urandom_range(0, 9));
        cyc();
      end
      $display("test_seed: counter %0d captured seed=%b", want, seed);
    end
  endtask

  task automatic test_final_score();
    score = 8'd0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i < ROUND; i++) begin
      score = 8'($urandom_range(0, 36));
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL final_model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    score = 8'd37;
    cyc();
    n_cmp++;
    if (final_score !== 8'd37 || game_over !== 1'b1 || game !== 1'b0 || time_left !== 7'd0) begin
      n_bad++;
      $display("FAIL final_capture: final=%0d over=%b game=%b time_left=%0d want 37 1 0 0",
               final_score, game_over, game, time_left);
    end
    score = 8'd0;
    repeat (3) begin
      cyc();
      n_cmp++;
      if (final_score !== 8'd37 || game_over !== 1'b1) begin
        n_bad++;
        $display("FAIL final_hold: final=%0d over=%b want 37 1", final_score, game_over);
      end
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++;
    if (game !== 1'b1 || level !== 2'd0 || time_left !== 7'(GS) || game_over !== 1'b0) begin
      n_bad++;
      $display("FAIL restart: game=%b level=%0d time_left=%0d over=%b", game, level, time_left, game_over);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL restart_model: got %h want %h", dut_vec, exp_vec());
    end
    $display("test_final_score: final_score=%0d, new round started", final_score);
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(1, 8)) begin
      score = 8'($urandom_range(0, 9));
      cyc();
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (game !== 1'b0) begin
      n_bad++;
      $display("FAIL async_drop: game=%b want 0 before any clock edge", game);
    end
    model_reset();
    n_cmp++;
    if (dut_vec !== {2'b00, 2'b01, 2'b00, BASE, 7'd0, 8'd0}) begin
      n_bad++;
      $display("FAIL mid_reset_values: got %h want %h", dut_vec, {2'b00, 2'b01, 2'b00, BASE, 7'd0, 8'd0});
    end
    @(negedge clock);
    reset_n = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_cmp++;
    if (game !== 1'b1 || time_left !== 7'(GS)) begin
      n_bad++;
      $display("FAIL fresh_round: game=%b time_left=%0d want 1 %0d", game, time_left, GS);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++;
      $display("FAIL fresh_round_model: got %h want %h", dut_vec, exp_vec());
    end
    $display("test_reset_mid: reset mid-round, fresh round seed=%b", seed);
  endtask

  task automatic test_random();
    logic over_prev;
    over_prev = game_over;
    for (int i = 0; i < 400; i++) begin
      score = 8'($urandom_range(0, 9));
      start = ($urandom_range(0, 15) == 0);
      cyc();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      if (game_over && !over_prev) begin
        $display("test_random: round end final_score=%0d level=%0d seed=%b", final_score, level, seed);
      end
      over_prev = game_over;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_round_timing();
    test_level_steps();
    test_jump();
    test_seed();
    test_final_score();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/level_controller.md
# level_controller

Game-level sequencer that sits directly upstream of the whack-a-mole `top` datapath. It owns the game session, in this order: a start button opens a timed round, it drives `game`, `seed` and `speed` into `top`, and it raises the level, shortening the mole period, as `top`'s `score` climbs. When the round timer expires it latches the final score for the display stage and waits for the next start.

## Interface
- `CLK_HZ`, default 50_000_000: clock cycles per game second (prescaler terminal count + 1).
- `GAME_SECONDS`, default 60: round length in seconds, range 1..127.
- `LEVEL_STEP`, default 10: score points per level step.
- `BASE_SPEED`, default 28'd149_999_999: mole-period reload value at level 0.
- `clock` in 1: system clock, all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: debounced start button, active-high, synchronous to `clock`.
- `score` in 8: live score from `top`.
- `game` out 1: round active; feeds `top.game`.
- `seed` out 2: random-generator seed for `top`; never 2'b00.
- `speed` out 28: mole-period reload value for `top`.
- `level` out 2: current level, 0..3.
- `time_left` out 7: seconds remaining in the round.
- `game_over` out 1: high in OVER state.
- `final_score` out 8: score latched at round end.

## Operation
- States, in `whack_pkg`: IDLE, PLAY, OVER.
  - IDLE→PLAY on a start edge.
  - PLAY→OVER on the last second tick.
  - OVER→PLAY on a start edge.
  - IDLE is re-entered only via reset.
- Start edge: `start & ~start_q`, where `start_q` is a one-cycle delay of `start`.
  - `start_q` resets to 1, so a button held through reset release does not start a game.
  - Start edges during PLAY are ignored.
- Seed:
  - A free-running 2-bit counter increments every cycle.
  - On the accepted start edge its value is captured into `seed`.
  - A captured 2'b00 is replaced by 2'b01, because the downstream LFSR locks up at 00.
- Round entry, same edge:
  - `time_left` ← GAME_SECONDS.
  - `level` ← 0.
  - prescaler ← 0.
  - `game_over` ← 0.
- Prescaler (PLAY only):
  - Counts 0..CLK_HZ-1.
  - Emits a one-cycle `tick` when the count equals CLK_HZ-1, then wraps to 0.
  - Held at 0 outside PLAY.
- Timer, on `tick`:
  - If `time_left` > 1, decrement it.
  - If `time_left` == 1: set `time_left` ← 0, enter OVER, capture `final_score` ← `score`.
- Level update, PLAY only, at most one step per cycle:
  - Condition: `level` < 3 and `score` ≥ (level+1)·LEVEL_STEP.
  - Compute this product 9 bits wide to avoid overflow.
  - Level never decreases within a round, even if `score` drops.
- Speed: `speed` ← BASE_SPEED >> `level`, registered; level 3 yields BASE_SPEED/8.
- Outputs:
  - `game` = registered (state == PLAY).
  - `game_over` = registered (state == OVER).
  - `level`, `time_left` and `final_score` hold their values through OVER.

## Timing
- Reset values:
  - state IDLE
  - `game` 0, `game_over` 0
  - `seed` 2'b01
  - `speed` BASE_SPEED
  - `level` 0
  - `time_left` 0
  - `final_score` 0
  - prescaler 0, seed counter 0
- Start latency: with the start edge sampled at clock edge N, `game` = 1 after edge N.
- Round length: exactly GAME_SECONDS·CLK_HZ cycles of `game` = 1.
- Round end: `game` falls and `game_over`/`final_score` update on the same clock edge.
  - `final_score` captures `score` as sampled at that edge, before `top` clears the score one cycle later.
- Level latency: `level` changes one cycle after `score` crosses a threshold.
- Speed latency: `speed` follows one cycle after `level`.
- A jump of several thresholds at once takes one cycle per level step.
- Simultaneous tick-to-OVER and level threshold: OVER wins, and `level` is frozen.
- Reset asserted mid-round: immediate return to the reset values, with `game` dropping asynchronously.

## Structure
- `whack_pkg` holds:
  - state encodings as localparams: IDLE=2'd0, PLAY=2'd1, OVER=2'd2
  - MAX_LEVEL=2'd3
- Sub-module `second_ticker`:
  - inputs: `clock`, `reset_n`, `enable`
  - parameter: CLK_HZ
  - output: `tick`
  - internal counter sized to $clog2(CLK_HZ)
- Remaining logic lives in `level_controller`: FSM, edge detect, seed, timer, level/speed.

## Test plan
Common setup: CLK_HZ=4, GAME_SECONDS=3, LEVEL_STEP=2, BASE_SPEED=64.
- Reset release with `start` held high, then kept high for 10 cycles → `game` stays 0, state IDLE, `seed` = 01.
- Start pulse at cycle N → `game` = 1 from edge N, `time_left` = 3.
  - `time_left` reads 2, 1 at 4-cycle intervals.
  - `game` falls after exactly 12 cycles, `game_over` = 1, `time_left` = 0.
- `score` stepped 0, 2, 4, 6, 8 during PLAY → `level` = 0, 1, 2, 3, 3 and `speed` = 64, 32, 16, 8, 8.
  - Then `score` drops to 1 → `level` remains 3.
- Start edge timed so the seed counter reads 00 → `seed` = 01; reads 10 → `seed` = 10.
- `score` = 37 on the final tick → `final_score` = 37, held through OVER.
  - A new start edge → PLAY, with `level` 0 and `time_left` 3.
- `reset_n` pulsed low mid-round → `game` drops with no clock edge, all outputs return to reset values.
  - A start pulse after release begins a fresh round.
